// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_pkg
// Description : Shared encodings for the pipelined CPU execute stage: ALU
//               control codes, multiply/divide op codes, the mul/div FSM
//               state type and the link register index.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // ALU control codes (bit 3 is only significant for the right shifts)
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    // Multiply/divide operation codes
    localparam logic [2:0] MDOP_NONE  = 3'b000;
    localparam logic [2:0] MDOP_MULTU = 3'b001;
    localparam logic [2:0] MDOP_DIVU  = 3'b010;
    localparam logic [2:0] MDOP_MFHI  = 3'b011;
    localparam logic [2:0] MDOP_MFLO  = 3'b100;

    // Link register written by jump-and-link
    localparam logic [4:0] JAL_REG = 5'd31;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // True for the two ops that occupy the iterative unit
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == MDOP_MULTU) || (op == MDOP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_exe_stage_if.sv
`default_nettype none
// ============================================================================
// Interface   : pipe_exe_stage_if
// Description : ID/EX -> EX -> EX/MEM signal bundle of the execute stage.
//               master = pipeline side driving ID/EX values,
//               slave  = execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_exe_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] ea;
    logic [XLEN-1:0] eb;
    logic [XLEN-1:0] eimm;
    logic [XLEN-1:0] epc4;
    logic [3:0]      ealuc;
    logic            ealuimm;
    logic            eshift;
    logic            ejal;
    logic [4:0]      ern0;
    logic            ewreg_i;
    logic            em2reg_i;
    logic            ewmem_i;
    logic [2:0]      emdop;

    logic [XLEN-1:0] ealu;
    logic [4:0]      ern;
    logic            ewreg;
    logic            em2reg;
    logic            ewmem;
    logic            ebusy;

    modport master (
        output ea, eb, eimm, epc4, ealuc, ealuimm, eshift, ejal, ern0,
               ewreg_i, em2reg_i, ewmem_i, emdop,
        input  ealu, ern, ewreg, em2reg, ewmem, ebusy
    );

    modport slave (
        input  ea, eb, eimm, epc4, ealuc, ealuimm, eshift, ejal, ern0,
               ewreg_i, em2reg_i, ewmem_i, emdop,
        output ealu, ern, ewreg, em2reg, ewmem, ebusy
    );

endinterface
`default_nettype wire

// File: rtl/pipe_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_muldiv_unit
// Description : Iterative unsigned multiply (radix-2 shift-add) and divide
//               (restoring) unit with HI/LO result registers. One bit per
//               cycle; results land in HI/LO on the last iteration edge.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_muldiv_unit
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  wire logic            clock,
    input  wire logic            resetn,
    input  wire logic [2:0]      op,
    input  wire logic [XLEN-1:0] a,
    input  wire logic [XLEN-1:0] b,
    output logic                 busy,
    output logic [XLEN-1:0]      hi,
    output logic [XLEN-1:0]      lo
);

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               div_q;
    // Multiplicand (MULTU) or divisor (DIVU)
    logic [XLEN-1:0]    d_q;
    // Partial upper half: product high bits or running remainder
    logic [XLEN-1:0]    ph_q;
    logic [XLEN-1:0]    ph_d;
    // Partial lower half: remaining multiplier bits or dividend/quotient
    logic [XLEN-1:0]    pl_q;
    logic [XLEN-1:0]    pl_d;
    logic [XLEN-1:0]    hi_q;
    logic [XLEN-1:0]    lo_q;

    logic               w_start;
    logic [XLEN:0]      w_sum;
    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_trial;

    // A new op is accepted only from IDLE; the stall must be visible that same cycle
    assign w_start = (state_q == MD_IDLE) && is_iter_op(op);
    assign busy    = w_start || (state_q == MD_RUN);
    assign hi      = hi_q;
    assign lo      = lo_q;

    // One iteration step for either multiply or divide
    always_comb begin
        w_sum   = {1'b0, ph_q} + (pl_q[0] ? {1'b0, d_q} : {(XLEN+1){1'b0}});
        w_shift = {ph_q, pl_q[XLEN-1]};
        w_trial = w_shift - {1'b0, d_q};
        ph_d    = ph_q;
        pl_d    = pl_q;
        if (div_q) begin
            // Restoring divide: keep the subtraction only when it did not borrow
            if (!w_trial[XLEN]) begin
                ph_d = w_trial[XLEN-1:0];
                pl_d = {pl_q[XLEN-2:0], 1'b1};
            end else begin
                ph_d = w_shift[XLEN-1:0];
                pl_d = {pl_q[XLEN-2:0], 1'b0};
            end
        end else begin
            // Shift-add: the carry-out re-enters the top of the product
            ph_d = w_sum[XLEN:1];
            pl_d = {w_sum[0], pl_q[XLEN-1:1]};
        end
    end

    // Control FSM with operand latch, iteration counter and HI/LO update
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            d_q     <= '0;
            ph_q    <= '0;
            pl_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (w_start) begin
                        div_q   <= (op == MDOP_DIVU);
                        d_q     <= (op == MDOP_DIVU) ? b : a;
                        pl_q    <= (op == MDOP_DIVU) ? a : b;
                        ph_q    <= '0;
                        cnt_q   <= '0;
                        state_q <= MD_RUN;
                    end
                end
                MD_RUN: begin
                    ph_q  <= ph_d;
                    pl_q  <= pl_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        hi_q    <= ph_d;
                        lo_q    <= pl_d;
                        state_q <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    state_q <= MD_IDLE;
                end
                default: begin
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_exe_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_exe_stage
// Description : Execute stage of the 5-stage pipeline. Combinational ALU,
//               result/destination muxing, and an iterative multiply/divide
//               unit that stalls the front of the pipe through ebusy.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_exe_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  wire logic       clock,
    input  wire logic       resetn,
    pipe_exe_stage_if.slave ex
);

    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_result;
    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_lo;
    logic            w_busy;

    // Operand selection: shift amount comes from the immediate's shamt field
    assign w_a = ex.eshift  ? {{(XLEN-5){1'b0}}, ex.eimm[10:6]} : ex.ea;
    assign w_b = ex.ealuimm ? ex.eimm : ex.eb;

    // ALU: bit 3 of ealuc only distinguishes arithmetic from logical right shift
    always_comb begin
        w_alu = w_a + w_b;
        case (ex.ealuc[2:0])
            ALUC_ADD[2:0]: w_alu = w_a + w_b;
            ALUC_SUB[2:0]: w_alu = w_a - w_b;
            ALUC_AND[2:0]: w_alu = w_a & w_b;
            ALUC_OR[2:0]:  w_alu = w_a | w_b;
            ALUC_XOR[2:0]: w_alu = w_a ^ w_b;
            ALUC_LUI[2:0]: w_alu = w_b << 16;
            ALUC_SLL[2:0]: w_alu = w_b << w_a[CNT_W-1:0];
            ALUC_SRL[2:0]: begin
                if (ex.ealuc == ALUC_SRA) begin
                    w_alu = XLEN'($signed(w_b) >>> w_a[CNT_W-1:0]);
                end else begin
                    w_alu = w_b >> w_a[CNT_W-1:0];
                end
            end
            default:       w_alu = w_a + w_b;
        endcase
    end

    // Result priority: link address, then HI/LO moves, then the ALU
    always_comb begin
        w_result = w_alu;
        if (ex.ejal) begin
            w_result = ex.epc4 + XLEN'(4);
        end else if (ex.emdop == MDOP_MFHI) begin
            w_result = w_hi;
        end else if (ex.emdop == MDOP_MFLO) begin
            w_result = w_lo;
        end
    end

    pipe_muldiv_unit #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clock  (clock),
        .resetn (resetn),
        .op     (ex.emdop),
        .a      (ex.ea),
        .b      (ex.eb),
        .busy   (w_busy),
        .hi     (w_hi),
        .lo     (w_lo)
    );

    assign ex.ealu   = w_result;
    assign ex.ern    = ex.ejal ? JAL_REG : ex.ern0;
    // Squash writes while stalled so EX/MEM only sees bubbles
    assign ex.ewreg  = ex.ewreg_i  & ~w_busy;
    assign ex.em2reg = ex.em2reg_i & ~w_busy;
    assign ex.ewmem  = ex.ewmem_i  & ~w_busy;
    assign ex.ebusy  = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_pipe_exe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_exe_stage
// Description : Self-checking bench for pipe_exe_stage. A cycle-level model
//               predicts every output each cycle; directed vectors add
//               hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_exe_stage;

    logic clock;
    logic resetn;
    int   checks;
    int   failures;

    pipe_exe_stage_if #(.XLEN(32)) bus ();

    pipe_exe_stage #(
        .XLEN  (32),
        .CNT_W (5)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .ex     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    int          md_pos;   // 0 idle, 1..32 iterating, 33 finishing cycle
    logic [63:0] md_res;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    function automatic logic [31:0] alu_model(input logic [3:0] c,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        casez (c)
            4'b?000: return a + b;
            4'b?100: return a - b;
            4'b?001: return a & b;
            4'b?101: return a | b;
            4'b?010: return a ^ b;
            4'b?110: return {b[15:0], 16'h0000};
            4'b0011: return b << a[4:0];
            4'b0111: return b >> a[4:0];
            4'b1111: return $signed(b) >>> a[4:0];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] md_expect(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        if (op == 3'd1) return {32'd0, a} * {32'd0, b};
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
    endfunction

    function automatic logic is_md(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Occupancy model: 33 stalled cycles, HI/LO updated on the last stalled edge
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            md_pos <= 0;
            md_res <= 64'd0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
        end else if (md_pos == 0) begin
            if (is_md(bus.emdop)) begin
                md_pos <= 1;
                md_res <= md_expect(bus.emdop, bus.ea, bus.eb);
            end
        end else if (md_pos < 32) begin
            md_pos <= md_pos + 1;
        end else if (md_pos == 32) begin
            md_pos <= 33;
            m_hi   <= md_res[63:32];
            m_lo   <= md_res[31:0];
        end else begin
            md_pos <= 0;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clock) begin
        logic        e_busy;
        logic [31:0] a_op;
        logic [31:0] b_op;
        logic [31:0] e_alu;
        e_busy = (md_pos == 0 && is_md(bus.emdop)) || (md_pos >= 1 && md_pos <= 32);
        a_op   = bus.eshift  ? {27'd0, bus.eimm[10:6]} : bus.ea;
        b_op   = bus.ealuimm ? bus.eimm : bus.eb;
        if (bus.ejal)              e_alu = bus.epc4 + 32'd4;
        else if (bus.emdop == 3'd3) e_alu = m_hi;
        else if (bus.emdop == 3'd4) e_alu = m_lo;
        else                        e_alu = alu_model(bus.ealuc, a_op, b_op);
        chk("ealu",   bus.ealu, e_alu);
        chk("ern",    32'(bus.ern), 32'(bus.ejal ? 5'd31 : bus.ern0));
        chk("ebusy",  32'(bus.ebusy), 32'(e_busy));
        chk("ewreg",  32'(bus.ewreg), 32'(bus.ewreg_i & ~e_busy));
        chk("em2reg", 32'(bus.em2reg), 32'(bus.em2reg_i & ~e_busy));
        chk("ewmem",  32'(bus.ewmem), 32'(bus.ewmem_i & ~e_busy));
    end

    // ---------------- stimulus ----------------
    task automatic set_nop();
        bus.ea = 0; bus.eb = 0; bus.eimm = 0; bus.epc4 = 0;
        bus.ealuc = 0; bus.ealuimm = 0; bus.eshift = 0; bus.ejal = 0;
        bus.ern0 = 0; bus.ewreg_i = 0; bus.em2reg_i = 0; bus.ewmem_i = 0;
        bus.emdop = 0;
    endtask

    task automatic alu_t(input string name, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic aimm,
                         input logic sh, input logic [31:0] exp);
        set_nop();
        bus.ealuc = c; bus.ea = a; bus.eb = b; bus.eimm = imm;
        bus.ealuimm = aimm; bus.eshift = sh; bus.ewreg_i = 1'b1; bus.ern0 = 5'd3;
        @(negedge clock);
        chk(name, bus.ealu, exp);
        @(posedge clock); #1;
    endtask

    task automatic run_md(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int busy_n);
        busy_n = 0;
        set_nop();
        bus.emdop = op; bus.ea = a; bus.eb = b;
        bus.ewreg_i = 1'b1; bus.em2reg_i = 1'b1; bus.ewmem_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.ebusy) busy_n++;
            else break;
        end
        @(posedge clock); #1;
        set_nop();
    endtask

    task automatic mf(input logic [2:0] op, input string name, input logic [31:0] exp);
        set_nop();
        bus.emdop = op; bus.ewreg_i = 1'b1; bus.ern0 = 5'd8;
        @(negedge clock);
        chk(name, bus.ealu, exp);
        @(posedge clock); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        set_nop();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ealu",  bus.ealu, 32'h0);
        chk("rst_ern",   32'(bus.ern), 32'h0);
        chk("rst_ebusy", 32'(bus.ebusy), 32'h0);
        chk("rst_ewreg", 32'(bus.ewreg), 32'h0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;

        alu_t("add_imm", 4'b0000, 32'd5, 32'd0, 32'hFFFFFFFD, 1'b1, 1'b0, 32'd2);
        chk("add_busy", 32'(bus.ebusy), 32'h0);
        alu_t("sra",     4'b1111, 32'd0, 32'h80000000, 32'h00000100, 1'b0, 1'b1, 32'hF8000000);
        alu_t("add_wrap",4'b1000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 32'h0);
        alu_t("sub",     4'b0100, 32'd10, 32'd3, 32'd0, 1'b0, 1'b0, 32'd7);
        alu_t("sub_neg", 4'b1100, 32'd3, 32'd10, 32'd0, 1'b0, 1'b0, 32'hFFFFFFF9);
        alu_t("and",     4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 1'b0, 32'hF000F000);
        alu_t("or",      4'b0101, 32'hF0F0F0F0, 32'h0F0F0000, 32'd0, 1'b0, 1'b0, 32'hFFFFF0F0);
        alu_t("xor",     4'b0010, 32'hFFFF0000, 32'h0F0F0F0F, 32'd0, 1'b0, 1'b0, 32'hF0F00F0F);
        alu_t("lui",     4'b0110, 32'd0, 32'd0, 32'h00001234, 1'b1, 1'b0, 32'h12340000);
        alu_t("sll",     4'b0011, 32'h00000024, 32'd1, 32'd0, 1'b0, 1'b0, 32'h00000010);
        alu_t("srl",     4'b0111, 32'd0, 32'h80000000, 32'h000007C0, 1'b0, 1'b1, 32'h00000001);

        // Jump-and-link
        set_nop();
        bus.ejal = 1'b1; bus.epc4 = 32'h00001004; bus.ern0 = 5'd0; bus.ewreg_i = 1'b1;
        @(negedge clock);
        chk("jal_ealu", bus.ealu, 32'h00001008);
        chk("jal_ern",  32'(bus.ern), 32'd31);
        @(posedge clock); #1;

        // MULTU max*max
        run_md(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        chk("multu_busy_cycles", 32'(n), 32'd33);
        chk("model_hi_multu", m_hi, 32'hFFFFFFFE);
        mf(3'd3, "multu_hi", 32'hFFFFFFFE);
        mf(3'd4, "multu_lo", 32'h00000001);

        // DIVU 100/7
        run_md(3'd2, 32'd100, 32'd7, n);
        chk("divu_busy_cycles", 32'(n), 32'd33);
        mf(3'd4, "divu_lo", 32'd14);
        mf(3'd3, "divu_hi", 32'd2);

        // DIVU by zero
        run_md(3'd2, 32'h12345678, 32'd0, n);
        chk("div0_busy_cycles", 32'(n), 32'd33);
        chk("model_lo_div0", m_lo, 32'hFFFFFFFF);
        mf(3'd4, "div0_lo", 32'hFFFFFFFF);
        mf(3'd3, "div0_hi", 32'h12345678);

        // Reset in the middle of a MULTU
        set_nop();
        bus.emdop = 3'd1; bus.ea = 32'hFFFFFFFF; bus.eb = 32'hFFFFFFFF;
        repeat (10) @(negedge clock);
        chk("midop_busy", 32'(bus.ebusy), 32'h1);
        resetn = 1'b0;
        set_nop();
        #1;
        chk("abort_busy", 32'(bus.ebusy), 32'h0);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        @(posedge clock); #1;
        mf(3'd3, "abort_hi", 32'h0);
        mf(3'd4, "abort_lo", 32'h0);

        // DIVU 9/3 after the abort
        run_md(3'd2, 32'd9, 32'd3, n);
        chk("div93_busy_cycles", 32'(n), 32'd33);
        mf(3'd4, "div93_lo", 32'd3);
        mf(3'd3, "div93_hi", 32'd0);

        repeat (2) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
